// File: rtl/block_data_memory_if.sv
// ============================================================================
//  Module   : block_data_memory_if
//  Purpose  : Block-transfer bus between the data cache and block data memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface block_data_memory_if;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_writedata,
    input  mem_readdata,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_writedata,
    output mem_readdata,
    output mem_busywait
  );
endinterface

`default_nettype wire

// File: rtl/block_data_memory.sv
// ============================================================================
//  Module   : block_data_memory
//  Purpose  : 64 x 32-bit block memory answering cache block reads/writes
//             after a fixed LATENCY, stalling the initiator with busywait.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_data_memory #(
  parameter int LATENCY = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  block_data_memory_if.slave         bus,
  output logic                       mem_error,
  output logic [15:0]                read_count,
  output logic [15:0]                write_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] c_LOAD = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_req_one;
  logic        w_req_both;
  logic        w_accept;
  logic        w_complete;

  logic        r_op_write;
  logic [5:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_count;
  logic [31:0] r_readdata;
  logic [31:0] r_mem [0:63];

  assign w_req_one  = bus.mem_read ^ bus.mem_write;
  assign w_req_both = bus.mem_read & bus.mem_write;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_one) w_next_state = S_BUSY;
      S_BUSY:  if (r_count == 4'd0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: busywait rises in the same cycle a single request appears
  always_comb begin
    bus.mem_busywait = 1'b0;
    w_accept         = 1'b0;
    w_complete       = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.mem_busywait = w_req_one;
        w_accept         = w_req_one;
      end
      S_BUSY: begin
        bus.mem_busywait = 1'b1;
        w_complete       = (r_count == 4'd0);
      end
      default: begin
        bus.mem_busywait = 1'b0;
      end
    endcase
  end

  assign bus.mem_readdata = r_readdata;

  // Datapath: request latch, latency counter, array, statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op_write  <= 1'b0;
      r_addr      <= 6'd0;
      r_wdata     <= 32'd0;
      r_count     <= 4'd0;
      r_readdata  <= 32'd0;
      mem_error   <= 1'b0;
      read_count  <= 16'd0;
      write_count <= 16'd0;
      for (int i = 0; i < 64; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      if (w_accept) begin
        r_op_write <= bus.mem_write;
        r_addr     <= bus.mem_address;
        r_wdata    <= bus.mem_writedata;
        r_count    <= c_LOAD;
      end else if (r_state == S_BUSY && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end

      if (r_state == S_IDLE && w_req_both) begin
        mem_error <= 1'b1;
      end

      if (w_complete) begin
        if (r_op_write) begin
          r_mem[r_addr] <= r_wdata;
          if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
        end else begin
          r_readdata <= r_mem[r_addr];
          if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_data_memory.sv
// ============================================================================
//  Module   : tb_block_data_memory
//  Purpose  : Scoreboard bench for block_data_memory block read/write traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_data_memory;

  localparam int LATENCY = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_error;
  logic [15:0] read_count;
  logic [15:0] write_count;

  block_data_memory_if bus ();

  block_data_memory #(.LATENCY(LATENCY)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .mem_error   (mem_error),
    .read_count  (read_count),
    .write_count (write_count)
  );

  always #5 clock = ~clock;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] model_mem [64];
  logic [31:0] exp_readdata;
  int          exp_rc;
  int          exp_wc;
  logic [31:0] sb_q [$];

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    foreach (model_mem[i]) model_mem[i] = 32'd0;
    exp_readdata = 32'd0;
    exp_rc       = 0;
    exp_wc       = 0;
    sb_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_readdata"}, bus.mem_readdata, 32'd0);
    check_value({tag, "_busywait"}, {31'd0, bus.mem_busywait}, 32'd0);
    check_value({tag, "_error"}, {31'd0, mem_error}, 32'd0);
    check_value({tag, "_read_count"}, {16'd0, read_count}, 32'd0);
    check_value({tag, "_write_count"}, {16'd0, write_count}, 32'd0);
  endtask

  // Called just after a posedge; returns just after the posedge where the
  // initiator sees busywait low and drops its request.
  task automatic access(input logic wr, input logic [5:0] addr,
                        input logic [31:0] data, input bit disturb);
    int cycles;
    cycles            = 0;
    bus.mem_read      = ~wr;
    bus.mem_write     = wr;
    bus.mem_address   = addr;
    bus.mem_writedata = data;
    if (!wr) sb_q.push_back(model_mem[addr]);
    #1;
    check_value("busywait_on_request", {31'd0, bus.mem_busywait}, 32'd1);
    do begin
      @(posedge clock);
      #1;
      cycles++;
      if (disturb && cycles == 1) begin
        bus.mem_address   = ~addr;
        bus.mem_writedata = ~data;
      end
    end while (bus.mem_busywait && cycles < 40);
    check_value("completion_latency", cycles, LATENCY + 1);
    if (wr) begin
      model_mem[addr] = data;
      exp_wc++;
      check_value("readdata_kept_by_write", bus.mem_readdata, exp_readdata);
    end else begin
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL scoreboard_empty: observed empty queue expected entry");
      end else begin
        exp_readdata = sb_q.pop_front();
      end
      exp_rc++;
      check_value("read_data", bus.mem_readdata, exp_readdata);
    end
    check_value("read_count", {16'd0, read_count}, exp_rc);
    check_value("write_count", {16'd0, write_count}, exp_wc);
    @(posedge clock);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = 6'd0;
    bus.mem_writedata = 32'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Plain read of a cleared block
    access(1'b0, 6'h00, 32'd0, 1'b0);

    // Write then read back; readdata must not move on the write
    access(1'b1, 6'h2A, 32'hDEADBEEF, 1'b0);
    access(1'b0, 6'h2A, 32'd0, 1'b0);

    // Dirty eviction: write-back immediately followed by refill
    access(1'b1, 6'h05, 32'h11223344, 1'b0);
    access(1'b0, 6'h25, 32'd0, 1'b0);
    access(1'b0, 6'h05, 32'd0, 1'b0);

    // Inputs disturbed during BUSY must not leak into the write
    access(1'b1, 6'h10, 32'hA5A50F0F, 1'b1);
    access(1'b0, 6'h10, 32'd0, 1'b0);
    access(1'b0, 6'h2F, 32'd0, 1'b0);

    // Conflicting requests
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    #1;
    check_value("conflict_busywait", {31'd0, bus.mem_busywait}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check_value("conflict_error", {31'd0, mem_error}, 32'd1);
    check_value("conflict_busywait_held", {31'd0, bus.mem_busywait}, 32'd0);
    check_value("conflict_read_count", {16'd0, read_count}, exp_rc);
    check_value("conflict_write_count", {16'd0, write_count}, exp_wc);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clock);
    #1;
    check_value("error_sticky", {31'd0, mem_error}, 32'd1);
    reset = 1'b1;
    #1;
    check_outputs_zero("error_reset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Make readdata non-zero so the abort reset is observable
    access(1'b1, 6'h01, 32'h0BADCAFE, 1'b0);
    access(1'b0, 6'h01, 32'd0, 1'b0);

    // Reset in the middle of a write
    bus.mem_write     = 1'b1;
    bus.mem_address   = 6'h3F;
    bus.mem_writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clock);
    #1;
    check_value("abort_busy", {31'd0, bus.mem_busywait}, 32'd1);
    reset         = 1'b1;
    bus.mem_write = 1'b0;
    #1;
    check_outputs_zero("abort");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    access(1'b0, 6'h3F, 32'd0, 1'b0);
    access(1'b0, 6'h01, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/block_data_memory.md
# block_data_memory

Word-organised data memory that answers the data cache's block-transfer requests: the responder end of the `mem_read`/`mem_write`/`mem_busywait` interface. It stores 64 blocks of 32 bits (256 bytes) and serves one whole-block read or write per request after a fixed, parameterised latency. While busy it holds the initiator stalled with `mem_busywait`. It sits directly below the data cache in the CPU memory hierarchy.

## Interface
- `LATENCY`, 5, posedges from request acceptance to completion; legal range 1..15.
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high.
- `mem_read` in 1: block read request, level, held by the initiator until it sees `mem_busywait` low.
- `mem_write` in 1: block write request, level, same hold rule.
- `mem_address` in 6: block address; block A holds bytes 4A..4A+3.
- `mem_writedata` in 32: write block; byte 4A in [7:0], byte 4A+3 in [31:24].
- `mem_readdata` out 32: read block, same byte order, registered.
- `mem_busywait` out 1: stall to the initiator.
- `mem_error` out 1: sticky flag, set when `mem_read` and `mem_write` are both high in IDLE.
- `read_count` out 16: completed reads, saturating.
- `write_count` out 16: completed writes, saturating.

## Operation
- Storage is 64 x 32-bit registers.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Exactly one of `mem_read`/`mem_write` high at posedge: latch op, `mem_address`, `mem_writedata`; load down-counter with LATENCY-1; go to BUSY.
  - Both high: no accept, set `mem_error`, stay in IDLE.
  - Neither high: stay in IDLE.
- BUSY:
  - Counter > 0 at posedge: decrement it.
  - Counter = 0 at posedge: perform the latched op. A write stores the latched data to `mem[addr]`; a read loads `mem_readdata` from `mem[addr]`. Increment the matching counter, saturating at 16'hFFFF. Go to DONE.
- DONE: go to IDLE at the next posedge unconditionally. A request still high is not accepted in DONE.
- Input changes while in BUSY or DONE are ignored; only the latched values are used.
- `mem_busywait` is combinational: high in BUSY, or in IDLE when exactly one request is high. Low in DONE, and in IDLE with no request or with both requests high.
- `mem_readdata` holds its last value until the next read completes. Write completion does not change it.
- Reset value of every output is 0: `mem_readdata` = 0, `mem_busywait` = 0, `mem_error` = 0, `read_count` = 0, `write_count` = 0.
- Reset also puts the FSM in IDLE, clears the counter and clears all 64 words to 0.
- Reset mid-operation aborts the access. A pending write is not performed and no count increments.

## Timing
- Request accepted at posedge p. Op completes at posedge p+LATENCY. `mem_busywait` is low in the cycle between p+LATENCY and p+LATENCY+1.
- The initiator samples `mem_busywait` low at p+LATENCY+1, consumes `mem_readdata`, and drops its request. At that same posedge the memory returns to IDLE.
- Back-to-back case (write-back then refill): the initiator raises the new request right after p+LATENCY+1. `mem_busywait` rises combinationally in the same cycle, and the new request is accepted at the next posedge.
- `mem_busywait` rises in the same cycle the request is asserted. The initiator therefore never sees it low before acceptance.
- LATENCY=1: completion is at the posedge after acceptance, and BUSY lasts one cycle.
- Write-then-read of the same block returns the new data. The write is committed in the array before DONE.

## Test plan
- Reset, then read block 6'h00 with LATENCY=5. Required: `mem_busywait` is high from request through completion (5 posedges after accept); `mem_readdata` = 32'h0; `read_count` = 1.
- Write 32'hDEADBEEF to block 6'h2A, wait for busywait low, then read 6'h2A. Required: `mem_readdata` = 32'hDEADBEEF; `write_count` = 1; `read_count` = 1; `mem_readdata` unchanged by the write itself.
- Write 32'h11223344 to block 6'h05, then immediately read block 6'h25 (dirty eviction pattern). Required: the second accept occurs one posedge after the DONE->IDLE transition; block 6'h05 holds 32'h11223344; `mem_readdata` = 32'h0.
- Change `mem_address` and `mem_writedata` while in BUSY of a write to 6'h10. Required: only the originally latched address and data are written.
- Assert `mem_read` and `mem_write` together in IDLE. Required: `mem_error` = 1 and stays 1; `mem_busywait` = 0; no counts change. Then pulse `reset`: `mem_error` = 0.
- Assert `reset` during BUSY of a write of 32'hCAFEF00D to 6'h3F. Required: all outputs go to 0 immediately; a later read of 6'h3F returns 32'h0; `write_count` = 0.
